seg_scan_ctrl: RTL and testbench

Time-multiplexed driver for an N-digit common-anode seven-segment display on the Basys3 calculator datapath. It owns its own refresh divider and digit scan counter, snapshots the display inputs once per frame so digits never tear, and decodes hex nibbles to segments. It adds per-digit decimal points, per-digit blanking, leading-zero suppression and PWM brightness. It sits between the calculator result/format logic and the board's anode, segment and dp pins.

---
 rtl/seg_pkg.sv | 8 +
 rtl/seg_hex_decode.sv | 9 +
 rtl/seg_scan_ctrl.sv | 88 ++++++++
 tb/tb_seg_scan_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment constants for the scan controller
package seg_pkg;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: hex nibble to active-low {g,f,e,d,c,b,a} pattern
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scanner with frame snapshot, LZ blanking and PWM
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DUTY_BITS   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       digit_data,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic                          lz_en,
  input  logic [DUTY_BITS-1:0]          brightness,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_start
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int SUB_LEN = REFRESH_DIV >> DUTY_BITS;
  localparam int SW = SUB_LEN > 1 ? $clog2(SUB_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] LAST_SLICE = SW'(SUB_LEN - 1);
  logic                    init_done;
  logic [SW-1:0]           slice_cnt;
  logic [DUTY_BITS-1:0]    sub_cnt;
  logic [4*NUM_DIGITS-1:0] snap_data;
  logic [NUM_DIGITS-1:0]   snap_dp, snap_blank, supp;
  logic                    snap_lz;
  logic [DUTY_BITS-1:0]    snap_bright;
  logic                    slice_wrap, div_wrap, take_snap, zero_run, dark;
  logic [3:0]              nib;
  logic [6:0]              hex_seg;
  // div_cnt is kept split as {sub_cnt, slice_cnt} so the PWM phase needs no divider
  assign slice_wrap = slice_cnt == LAST_SLICE;
  assign div_wrap   = slice_wrap && &sub_cnt;
  assign take_snap  = !init_done || (div_wrap && digit_idx == LAST_IDX);
  always_comb begin
    zero_run = snap_lz;
    supp = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run = zero_run && snap_data[4*k +: 4] == 4'h0;
      supp[k] = zero_run;
    end
  end
  assign nib  = snap_data[4*digit_idx +: 4];
  assign dark = snap_blank[digit_idx] | supp[digit_idx];
  seg_hex_decode u_dec (.nib(nib), .seg(hex_seg));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done   <= 1'b0;
      slice_cnt   <= '0;
      sub_cnt     <= '0;
      digit_idx   <= '0;
      frame_start <= 1'b0;
      snap_data   <= '0;
      snap_dp     <= '0;
      snap_blank  <= '0;
      snap_lz     <= 1'b0;
      snap_bright <= '0;
      anode       <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
    end else begin
      init_done   <= 1'b1;
      frame_start <= take_snap;
      if (take_snap) begin
        snap_data   <= digit_data;
        snap_dp     <= dp_mask;
        snap_blank  <= blank_mask;
        snap_lz     <= lz_en;
        snap_bright <= brightness;
      end
      // the first cycle after release only loads the snapshot; scanning starts next cycle
      if (init_done) begin
        slice_cnt <= slice_wrap ? '0 : slice_cnt + 1'b1;
        if (slice_wrap) sub_cnt <= sub_cnt + 1'b1;
        if (div_wrap) digit_idx <= digit_idx == LAST_IDX ? '0 : digit_idx + 1'b1;
        anode <= (!dark && sub_cnt <= snap_bright) ? ~(NUM_DIGITS'(1) << digit_idx) : '1;
        seg   <= dark ? SEG_OFF : hex_seg;
        dp    <= dark | ~snap_dp[digit_idx];
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench with a frame-level reference model
module tb_seg_scan_ctrl;
  localparam int ND = 4, RD = 16, DB = 2, FRAME = ND * RD;
  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    logic       fs;
  } obs_t;
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dpm;
    logic [3:0]  blk;
    logic        lz;
    logic [1:0]  br;
  } frame_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] digit_data = '0;
  logic [3:0] dp_mask = '0, blank_mask = '0;
  logic lz_en = 1'b0;
  logic [1:0] brightness = '0;
  logic [3:0] anode;
  logic [6:0] seg;
  logic dp, frame_start;
  logic [1:0] digit_idx;
  obs_t exp_q[$];
  frame_t plan[$];
  int checks = 0, errors = 0;
  bit mon_en = 1'b0;
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  always #5 clk = ~clk;
  seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DUTY_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .digit_data(digit_data), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .lz_en(lz_en), .brightness(brightness), .anode(anode),
    .seg(seg), .dp(dp), .digit_idx(digit_idx), .frame_start(frame_start)
  );
  task automatic check(input string name, input obs_t act, input obs_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got anode=%h seg=%h dp=%b idx=%0d fs=%b, want anode=%h seg=%h dp=%b idx=%0d fs=%b",
               name, $time, act.anode, act.seg, act.dp, act.idx, act.fs,
               want.anode, want.seg, want.dp, want.idx, want.fs);
    end
  endtask
  function automatic obs_t observe();
    return {anode, seg, dp, digit_idx, frame_start};
  endfunction
  // one entry per output cycle of a frame, derived from the display rules directly
  task automatic push_frame(input frame_t f);
    for (int j = 0; j < FRAME; j++) begin
      int s, sub;
      bit off;
      obs_t o;
      s = j / RD;
      sub = (j % RD) / (RD >> DB);
      off = f.blk[s];
      if (f.lz && s != 0 && (f.data >> (4 * s)) == 0) off = 1'b1;
      o.anode = (!off && sub <= int'(f.br)) ? ~(4'b0001 << s) : 4'hF;
      o.seg = off ? 7'h7F : hex_tab[f.data[4*s +: 4]];
      o.dp = off | ~f.dpm[s];
      o.idx = 2'(((j + 1) / RD) % ND);
      o.fs = j == FRAME - 1;
      exp_q.push_back(o);
    end
  endtask
  function automatic frame_t rand_frame();
    frame_t f;
    f.data = 16'($urandom) >> (4 * $urandom_range(0, 4));
    f.dpm = 4'($urandom);
    f.blk = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0;
    f.lz = 1'($urandom);
    f.br = 2'($urandom);
    return f;
  endfunction
  function automatic frame_t next_frame(input bit last);
    frame_t f;
    f = plan.size() != 0 ? plan.pop_front() : rand_frame();
    if (last) begin
      f.lz = 1'b0;
      f.blk = 4'h0;
      f.br = 2'b11;
    end
    return f;
  endfunction
  task automatic apply(input frame_t f);
    {digit_data, dp_mask, blank_mask, lz_en, brightness} = f;
  endtask
  // runs n frames from reset release, then asserts reset in slot 2 of the last frame
  task automatic run_session(input int n);
    frame_t f;
    f = next_frame(n == 1);
    apply(f);
    exp_q.push_back({4'hF, 7'h7F, 1'b1, 2'd0, 1'b1});
    push_frame(f);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      repeat (20) @(negedge clk);
      apply(rand_frame());
      if (i < n - 1) begin
        repeat (44) @(negedge clk);
        f = next_frame(i == n - 2);
        apply(f);
        push_frame(f);
      end else begin
        repeat (20) @(negedge clk);
      end
    end
    mon_en = 1'b0;
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1 check("async_reset", observe(), {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
    repeat (3) @(negedge clk);
  endtask
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL underflow at %0t: DUT output with no expected entry, got anode=%h seg=%h", $time, anode, seg);
      end else begin
        check("scan", observe(), exp_q.pop_front());
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
  initial begin
    plan.push_back({16'h1234, 4'h0, 4'h0, 1'b0, 2'b11});
    plan.push_back({16'h0050, 4'h0, 4'h0, 1'b1, 2'b11});
    plan.push_back({16'h0050, 4'h0, 4'h0, 1'b0, 2'b11});
    plan.push_back({16'hA7C9, 4'b0100, 4'b0001, 1'b0, 2'b11});
    plan.push_back({16'h8E0F, 4'h0, 4'h0, 1'b0, 2'b01});
    plan.push_back({16'hD0B6, 4'hF, 4'h0, 1'b0, 2'b00});
    plan.push_back({16'h0000, 4'h3, 4'h0, 1'b1, 2'b11});
    repeat (3) @(negedge clk);
    check("reset_state", observe(), {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
    run_session(16);
    run_session(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
